itcm_arb: RTL and testbench

//  Arbitrates the single-port ITCM SRAM (1024 x 32) between the core instruction-fetch port (IFU) and the load/store port (LSU).

---
 rtl/itcm_arb.sv | 211 +++++++++++++++++++++
 tb/tb_itcm_arb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_arb.sv
// itcm_arb: single-port ITCM SRAM arbiter between IFU fetch and LSU port.
// Build option: define ITCM_ARB_RR_EN for round-robin, else LSU priority.
//
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  ifu_req_*           IFU read request (valid/ready, byte address)
//  ifu_rsp_*           IFU read response (valid/ready, data)
//  lsu_req_*           LSU request (valid/ready, addr, we, wstrb, wdata)
//  lsu_rsp_*           LSU response (valid/ready, data; 0 for writes)
//  ram_*               SRAM macro port, read data one cycle after ram_cs
module itcm_arb #(
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [31:0]       ifu_rsp_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_we,
  input  logic [3:0]        lsu_req_wstrb,
  input  logic [31:0]       lsu_req_wdata,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [31:0]       lsu_rsp_rdata,
  output logic              ram_cs,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic {
    P_IFU = 1'b0,
    P_LSU = 1'b1
  } port_e;

  // stage 1: the beat whose SRAM data arrives this cycle
  logic        s1_vld;
  port_e       s1_port;
  logic        s1_we;

  // one-entry hold buffers per port
  logic        ifu_hold_vld;
  logic [31:0] ifu_hold_data;
  logic        lsu_hold_vld;
  logic [31:0] lsu_hold_data;

  logic        ifu_s1;
  logic        lsu_s1;
  logic [31:0] s1_data;
  logic        ifu_elig;
  logic        lsu_elig;
  logic        ifu_cand;
  logic        lsu_cand;
  logic        ifu_win;
  logic        lsu_win;

  // byte offset bits never reach the SRAM
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^{ifu_req_addr[1:0], lsu_req_addr[1:0]};

  assign ifu_s1  = s1_vld & (s1_port == P_IFU);
  assign lsu_s1  = s1_vld & (s1_port == P_LSU);
  assign s1_data = s1_we ? 32'h0 : ram_rdata;

  // a port may issue only if its response has somewhere to go
  assign ifu_elig = ~ifu_hold_vld & (~ifu_s1 | ifu_rsp_ready);
  assign lsu_elig = ~lsu_hold_vld & (~lsu_s1 | lsu_rsp_ready);

  assign ifu_cand = ~rst & ifu_req_valid & ifu_elig;
  assign lsu_cand = ~rst & lsu_req_valid & lsu_elig;

`ifdef ITCM_ARB_RR_EN
  port_e rr_ptr;

  assign ifu_win = ifu_cand & (~lsu_cand | (rr_ptr == P_IFU));

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= P_IFU;
    end else if (ifu_win) begin
      rr_ptr <= P_LSU;
    end else if (lsu_win) begin
      rr_ptr <= P_IFU;
    end
  end
`else
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt;

  // starvation guard lets IFU through once it has waited long enough
  assign ifu_win = ifu_cand & (~lsu_cand | (wait_cnt == WMAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (~ifu_req_valid | ifu_win) begin
      wait_cnt <= '0;
    end else if (ifu_cand & (wait_cnt != WMAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif

  assign lsu_win = lsu_cand & ~ifu_win;

  assign ifu_req_ready = ifu_win;
  assign lsu_req_ready = lsu_win;

  always_comb begin
    ram_cs    = ifu_win | lsu_win;
    ram_we    = 4'h0;
    ram_wdata = 32'h0;
    ram_addr  = ifu_req_addr[ADDR_W-1:2];
    if (lsu_win) begin
      ram_addr  = lsu_req_addr[ADDR_W-1:2];
      ram_wdata = lsu_req_wdata;
      if (lsu_req_we) begin
        ram_we = lsu_req_wstrb;
      end
    end
  end

  // hold output takes priority; reset suppresses in-flight beats
  always_comb begin
    ifu_rsp_valid = 1'b0;
    ifu_rsp_rdata = 32'h0;
    if (!rst) begin
      unique case (1'b1)
        ifu_hold_vld: begin
          ifu_rsp_valid = 1'b1;
          ifu_rsp_rdata = ifu_hold_data;
        end
        ifu_s1: begin
          ifu_rsp_valid = 1'b1;
          ifu_rsp_rdata = s1_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lsu_rsp_valid = 1'b0;
    lsu_rsp_rdata = 32'h0;
    if (!rst) begin
      unique case (1'b1)
        lsu_hold_vld: begin
          lsu_rsp_valid = 1'b1;
          lsu_rsp_rdata = lsu_hold_data;
        end
        lsu_s1: begin
          lsu_rsp_valid = 1'b1;
          lsu_rsp_rdata = s1_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_port <= P_IFU;
      s1_we   <= 1'b0;
    end else begin
      s1_vld  <= ifu_win | lsu_win;
      s1_port <= lsu_win ? P_LSU : P_IFU;
      s1_we   <= lsu_win & lsu_req_we;
    end
  end

  // SRAM data is only valid for one cycle, so a stalled beat is parked
  always_ff @(posedge clk) begin
    if (rst) begin
      ifu_hold_vld  <= 1'b0;
      ifu_hold_data <= 32'h0;
    end else if (ifu_hold_vld) begin
      if (ifu_rsp_ready) begin
        ifu_hold_vld <= 1'b0;
      end
    end else if (ifu_s1 & ~ifu_rsp_ready) begin
      ifu_hold_vld  <= 1'b1;
      ifu_hold_data <= s1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_hold_vld  <= 1'b0;
      lsu_hold_data <= 32'h0;
    end else if (lsu_hold_vld) begin
      if (lsu_rsp_ready) begin
        lsu_hold_vld <= 1'b0;
      end
    end else if (lsu_s1 & ~lsu_rsp_ready) begin
      lsu_hold_vld  <= 1'b1;
      lsu_hold_data <= s1_data;
    end
  end

endmodule

// File: tb/tb_itcm_arb.sv
// tb_itcm_arb: directed self-checking bench for itcm_arb.
// Holds a behavioural 1024x32 SRAM model behind the ram_* port.
module tb_itcm_arb;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [11:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [11:0] lsu_req_addr;
  logic        lsu_req_we;
  logic [3:0]  lsu_req_wstrb;
  logic [31:0] lsu_req_wdata;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        ram_cs;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:1023];

  int tests;
  int fails;

  itcm_arb #(.ADDR_W(12), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_rdata (ifu_rsp_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_we    (lsu_req_we),
    .lsu_req_wstrb (lsu_req_wstrb),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .ram_cs        (ram_cs),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      tests++;
      if ({ifu_req_ready, lsu_req_ready, ram_cs,
           ifu_rsp_valid, lsu_rsp_valid} !== 5'b0) begin
        fails++;
        $display("FAIL reset_outs cyc%0d got %b%b%b%b%b want 00000", i,
                 ifu_req_ready, lsu_req_ready, ram_cs,
                 ifu_rsp_valid, lsu_rsp_valid);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({lsu_req_ready, ifu_req_ready, ram_cs} !== 3'b101) begin
      fails++;
      $display("FAIL reset_first_grant got lsu=%b ifu=%b cs=%b want 1 0 1",
               lsu_req_ready, ifu_req_ready, ram_cs);
    end
    @(negedge clk);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    #1;
    tests++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'h100137b7) begin
      fails++;
      $display("FAIL reset_first_rsp got v=%b d=%h want 1 100137b7",
               lsu_rsp_valid, lsu_rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_ifu_stream();
    logic [31:0] exp [0:2];
    exp[0] = 32'h100137b7;
    exp[1] = 32'h00878793;
    exp[2] = 32'h00100713;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifu_req_valid = (i < 3);
      ifu_req_addr  = 12'(4 * i);
      #1;
      if (i < 3) begin
        tests++;
        if (ifu_req_ready !== 1'b1) begin
          fails++;
          $display("FAIL ifu_stream_grant%0d got %b want 1", i, ifu_req_ready);
        end
      end
      if (i > 0) begin
        tests++;
        if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== exp[i-1]) begin
          fails++;
          $display("FAIL ifu_stream_rsp%0d got v=%b d=%h want 1 %h",
                   i - 1, ifu_rsp_valid, ifu_rsp_rdata, exp[i-1]);
        end
      end
    end
    @(negedge clk); #1;
    tests++;
    if (ifu_rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL ifu_stream_idle got v=%b want 0", ifu_rsp_valid);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_req_we    = 1'b1;
    lsu_req_addr  = 12'h040;
    lsu_req_wstrb = 4'b0011;
    lsu_req_wdata = 32'hAABBCCDD;
    #1;
    tests++;
    if (lsu_req_ready !== 1'b1 || ram_we !== 4'b0011 || ram_addr !== 10'h010) begin
      fails++;
      $display("FAIL sw_grant got rdy=%b we=%b a=%h want 1 0011 010",
               lsu_req_ready, ram_we, ram_addr);
    end
    @(negedge clk);
    lsu_req_we = 1'b0;
    #1;
    tests++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'h0 ||
        lsu_req_ready !== 1'b1 || ram_we !== 4'h0) begin
      fails++;
      $display("FAIL sw_rsp got v=%b d=%h rdy=%b we=%b want 1 0 1 0",
               lsu_rsp_valid, lsu_rsp_rdata, lsu_req_ready, ram_we);
    end
    @(negedge clk);
    lsu_req_valid = 1'b0;
    #1;
    tests++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'h1122CCDD) begin
      fails++;
      $display("FAIL lw_rsp got v=%b d=%h want 1 1122ccdd",
               lsu_rsp_valid, lsu_rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic exp_ifu;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 12'h000;
      lsu_req_valid = 1'b1;
      lsu_req_we    = 1'b0;
      lsu_req_addr  = 12'h004;
      #1;
      exp_ifu = ((i % 5) == 4);
      tests++;
      if (ifu_req_ready !== exp_ifu || lsu_req_ready !== !exp_ifu) begin
        fails++;
        $display("FAIL contention_cyc%0d got ifu=%b lsu=%b want %b %b",
                 i, ifu_req_ready, lsu_req_ready, exp_ifu, !exp_ifu);
      end
    end
    @(negedge clk);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 12'h008;
    ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b0;
    #1;
    tests++;
    if (ifu_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_grant got %b want 1", ifu_req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifu_rsp_ready = (i == 3);
      lsu_req_valid = 1'b1;
      lsu_req_we    = 1'b0;
      lsu_req_addr  = 12'h040;
      #1;
      tests++;
      if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== 32'h00100713 ||
          ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold%0d got v=%b d=%h irdy=%b lrdy=%b want 1 00100713 0 1",
                 i, ifu_rsp_valid, ifu_rsp_rdata, ifu_req_ready, lsu_req_ready);
      end
    end
    @(negedge clk);
    lsu_req_valid = 1'b0;
    #1;
    tests++;
    if (ifu_rsp_valid !== 1'b0 || ifu_req_ready !== 1'b1 ||
        lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'h1122CCDD) begin
      fails++;
      $display("FAIL bp_drained got iv=%b irdy=%b lv=%b ld=%h want 0 1 1 1122ccdd",
               ifu_rsp_valid, ifu_req_ready, lsu_rsp_valid, lsu_rsp_rdata);
    end
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    tests++;
    if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== 32'h00100713) begin
      fails++;
      $display("FAIL bp_after got v=%b d=%h want 1 00100713",
               ifu_rsp_valid, ifu_rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_midop_reset();
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_req_we    = 1'b0;
    lsu_req_addr  = 12'h040;
    #1;
    tests++;
    if (lsu_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_grant got %b want 1", lsu_req_ready);
    end
    @(negedge clk);
    lsu_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (lsu_rsp_valid !== 1'b0 || ram_cs !== 1'b0) begin
      fails++;
      $display("FAIL midrst_in_rst got v=%b cs=%b want 0 0",
               lsu_rsp_valid, ram_cs);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (lsu_rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_after got v=%b want 0", lsu_rsp_valid);
    end
    tests++;
    if (mem[16] !== 32'h1122CCDD) begin
      fails++;
      $display("FAIL midrst_mem got %h want 1122ccdd", mem[16]);
    end
    @(negedge clk);
    lsu_req_valid = 1'b1;
    #1;
    tests++;
    if (lsu_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_regrant got %b want 1", lsu_req_ready);
    end
    @(negedge clk);
    lsu_req_valid = 1'b0;
    #1;
    tests++;
    if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'h1122CCDD) begin
      fails++;
      $display("FAIL midrst_reread got v=%b d=%h want 1 1122ccdd",
               lsu_rsp_valid, lsu_rsp_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]  = 32'h100137b7;
    mem[1]  = 32'h00878793;
    mem[2]  = 32'h00100713;
    mem[16] = 32'h11223344;
    ram_rdata     = 32'h0;
    rst           = 1'b1;
    ifu_req_valid = 1'b0;
    ifu_req_addr  = 12'h000;
    ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b0;
    lsu_req_addr  = 12'h000;
    lsu_req_we    = 1'b0;
    lsu_req_wstrb = 4'h0;
    lsu_req_wdata = 32'h0;
    lsu_rsp_ready = 1'b1;

    test_reset();
    test_ifu_stream();
    test_write_read();
    test_contention();
    test_backpressure();
    test_midop_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
